// File: rtl/execute_md.sv
// RV32IM execute stage: forwarding muxes, ALU, branch condition and an iterative multiply/divide unit.
// Optional build macro MD_EARLY_OUT_EN lets divide-by-zero, signed overflow and zero-operand multiplies finish in 2 cycles.
module execute_md #(
    parameter int XLEN   = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ALUSrcE,
    input  logic [3:0]      ALUControlE,
    input  logic            MDEnE,
    input  logic [2:0]      MDOpE,
    input  logic            BranchE,
    input  logic [2:0]      BrFunctE,
    input  logic [XLEN-1:0] rs1_dataE,
    input  logic [XLEN-1:0] rs2_dataE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    input  logic            StallE,
    input  logic            FlushE,
    output logic [XLEN-1:0] ALUResultE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            cond_trueE,
    output logic            md_stallE
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN);

    localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR   = 4'b0011, ALU_XOR  = 4'b0100, ALU_SLT = 4'b0101,
                           ALU_SLTU = 4'b0110, ALU_SLL  = 4'b0111, ALU_SRL = 4'b1000,
                           ALU_SRA  = 4'b1001, ALU_LUI  = 4'b1010;
    localparam logic [2:0] MD_MUL = 3'b000, MD_MULH = 3'b001, MD_MULHSU = 3'b010, MD_MULHU = 3'b011,
                           MD_DIV = 3'b100, MD_DIVU = 3'b101, MD_REM    = 3'b110, MD_REMU  = 3'b111;

    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} md_state_t;

    md_state_t          state_r, state_nx;
    logic [CW-1:0]      cnt_r;
    logic [XLEN-1:0]    hi_r, lo_r, op_b_r, res_r;
    logic [2:0]         op_r;
    logic               sa_r, sb_r, div0_r;

    logic [XLEN-1:0]    src_a, fwd_b, src_b, alu_res;
    logic               cond_s, issue_s, finish_s;
    logic               sgn_a_s, sgn_b_s, neg_a_s, neg_b_s, div0_s;
    logic [XLEN-1:0]    abs_a_s, abs_b_s;
    logic [XLEN:0]      mul_sum_s, shift_rem_s;
    logic [XLEN-1:0]    rem_sub_s, hi_nx, lo_nx, md_res;
    logic [2*XLEN-1:0]  prod_s, prod_signed_s;
    logic [XLEN-1:0]    quo_signed_s, rem_signed_s;
`ifdef MD_EARLY_OUT_EN
    logic               ovf_s, mzero_s, early_s;
    logic [XLEN-1:0]    eo_res_s;
`endif

    // Forwarding muxes; code 11 falls back to the register value
    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = rs1_dataE;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = rs2_dataE;
        endcase
    end

    assign src_b      = ALUSrcE ? ImmExtE : fwd_b;
    assign WriteDataE = fwd_b;
    assign PCTargetE  = PCE + ImmExtE;

    // Combinational ALU
    always_comb begin
        case (ALUControlE)
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:  alu_res = src_a << src_b[SHW-1:0];
            ALU_SRL:  alu_res = src_a >> src_b[SHW-1:0];
            ALU_SRA:  alu_res = $signed(src_a) >>> src_b[SHW-1:0];
            ALU_LUI:  alu_res = src_b;
            default:  alu_res = '0;
        endcase
    end

    // Branch condition on forwarded rs1/rs2, independent of ALUSrcE
    always_comb begin
        case (BrFunctE)
            3'b000:  cond_s = (src_a == fwd_b);
            3'b001:  cond_s = (src_a != fwd_b);
            3'b100:  cond_s = ($signed(src_a) <  $signed(fwd_b));
            3'b101:  cond_s = ($signed(src_a) >= $signed(fwd_b));
            3'b110:  cond_s = (src_a <  fwd_b);
            3'b111:  cond_s = (src_a >= fwd_b);
            default: cond_s = 1'b0;
        endcase
    end

    assign cond_trueE = BranchE & cond_s;
    assign ALUResultE = (state_r == DONE) ? res_r : alu_res;

    // Issue decode: operand signedness, magnitudes and special cases
    always_comb begin
        sgn_a_s = (MDOpE == MD_MULH) || (MDOpE == MD_MULHSU) || (MDOpE == MD_DIV) || (MDOpE == MD_REM);
        sgn_b_s = (MDOpE == MD_MULH) || (MDOpE == MD_DIV) || (MDOpE == MD_REM);
        neg_a_s = sgn_a_s & src_a[XLEN-1];
        neg_b_s = sgn_b_s & fwd_b[XLEN-1];
        abs_a_s = neg_a_s ? -src_a : src_a;
        abs_b_s = neg_b_s ? -fwd_b : fwd_b;
        div0_s  = MDOpE[2] & (fwd_b == '0);
    end

`ifdef MD_EARLY_OUT_EN
    // Results known at issue time, bypassing the iteration
    always_comb begin
        ovf_s    = MDOpE[2] & ~MDOpE[0] & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (fwd_b == '1);
        mzero_s  = ~MDOpE[2] & ((src_a == '0) | (fwd_b == '0));
        early_s  = div0_s | ovf_s | mzero_s;
        if (!MDOpE[2] || !DIV_EN) begin
            eo_res_s = '0;
        end else if (div0_s) begin
            eo_res_s = MDOpE[1] ? src_a : '1;
        end else begin
            eo_res_s = MDOpE[1] ? '0 : src_a;
        end
    end
`endif

    // One iteration: shift-add multiply step or restoring divide step, plus final sign correction
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, op_b_r} : '0);
        shift_rem_s = {hi_r, lo_r[XLEN-1]};
        rem_sub_s   = shift_rem_s[XLEN-1:0] - op_b_r;
        if (op_r[2] && DIV_EN) begin
            if (shift_rem_s >= {1'b0, op_b_r}) begin
                hi_nx = rem_sub_s;
                lo_nx = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                hi_nx = shift_rem_s[XLEN-1:0];
                lo_nx = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nx = mul_sum_s[XLEN:1];
            lo_nx = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
        prod_s        = {hi_nx, lo_nx};
        prod_signed_s = (sa_r ^ sb_r) ? -prod_s : prod_s;
        quo_signed_s  = (sa_r ^ sb_r) ? -lo_nx : lo_nx;
        rem_signed_s  = sa_r ? -hi_nx : hi_nx;
        if (op_r[2] && !DIV_EN) begin
            md_res = '0;
        end else begin
            case (op_r)
                MD_MUL:                         md_res = prod_signed_s[XLEN-1:0];
                MD_MULH, MD_MULHSU, MD_MULHU:   md_res = prod_signed_s[2*XLEN-1:XLEN];
                MD_DIV, MD_DIVU:                md_res = div0_r ? '1 : quo_signed_s;
                MD_REM, MD_REMU:                md_res = rem_signed_s;
                default:                        md_res = '0;
            endcase
        end
    end

    // M-unit next state and stall request
    always_comb begin
        state_nx  = state_r;
        md_stallE = 1'b0;
        issue_s   = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (MDEnE && !FlushE) begin
                    issue_s   = 1'b1;
                    md_stallE = rst_n;
`ifdef MD_EARLY_OUT_EN
                    state_nx  = early_s ? DONE : BUSY;
`else
                    state_nx  = BUSY;
`endif
                end else begin
                    state_nx  = IDLE;
                end
            end
            BUSY: begin
                md_stallE = 1'b1;
                if (FlushE) begin
                    state_nx = IDLE;
                end else if (cnt_r == CW'(XLEN-1)) begin
                    state_nx = DONE;
                    finish_s = 1'b1;
                end else begin
                    state_nx = BUSY;
                end
            end
            DONE: begin
                if (FlushE) begin
                    state_nx = IDLE;
                end else if (StallE) begin
                    state_nx = DONE;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // M-unit state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // M-unit operand, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= '0;
            hi_r   <= '0;
            lo_r   <= '0;
            op_b_r <= '0;
            res_r  <= '0;
            op_r   <= 3'b000;
            sa_r   <= 1'b0;
            sb_r   <= 1'b0;
            div0_r <= 1'b0;
        end else if (issue_s) begin
            cnt_r  <= '0;
            hi_r   <= '0;
            lo_r   <= abs_a_s;
            op_b_r <= abs_b_s;
            op_r   <= MDOpE;
            sa_r   <= neg_a_s;
            sb_r   <= neg_b_s;
            div0_r <= div0_s;
`ifdef MD_EARLY_OUT_EN
            res_r  <= eo_res_s;
`endif
        end else if (state_r == BUSY) begin
            cnt_r <= cnt_r + 1'b1;
            hi_r  <= hi_nx;
            lo_r  <= lo_nx;
            if (finish_s) begin
                res_r <= md_res;
            end
        end
    end
endmodule

// File: doc/execute_md.md
Name: execute_md

Overview:
- Parametrised next-generation execute stage for the RV32IM pipelined core.
- Keeps the EX forwarding muxes, ALU path, branch target and store-data output of the current stage.
- Adds full RISC-V branch-condition evaluation and an iterative multiply/divide unit (M extension).
- The M unit stalls the pipeline through the hazard unit while it runs.
- Sits between the ID/EX and EX/MEM registers.

Parameters:
- XLEN, 32, datapath width; every data port is XLEN bits.
- DIV_EN, 1, when 0 the divider is omitted and DIV/DIVU/REM/REMU return 0 with MUL-class latency.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ALUSrcE  in  1  SrcB select: 1 = ImmExtE, 0 = forwarded rs2
- ALUControlE  in  4  ALU op, same encoding as the ALU package (ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ...)
- MDEnE  in  1  instruction in EX is an M-extension op
- MDOpE  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- BranchE  in  1  instruction in EX is a conditional branch
- BrFunctE  in  3  branch funct3
- rs1_dataE, rs2_dataE, ImmExtE, PCE  in  XLEN  ID/EX operands
- ForwardAE, ForwardBE  in  2  forwarding select: 00 reg, 01 ResultW, 10 ALUResultM
- ALUResultM, ResultW  in  XLEN  forwarded data
- StallE  in  1  hazard unit freezing EX for another reason
- FlushE  in  1  kill the instruction in EX
- ALUResultE  out  XLEN  result to EX/MEM
- WriteDataE  out  XLEN  forwarded rs2
- PCTargetE  out  XLEN  PCE + ImmExtE, modulo 2^XLEN
- cond_trueE  out  1  branch taken
- md_stallE  out  1  stall request to the hazard unit (freeze F/D/E, bubble into M)

Behaviour:
- Forwarding:
  - SrcA/SrcB muxes as per the encoding above; code 11 selects the register value.
  - WriteDataE is always the forwarded rs2.
- ALU ops are combinational; ALUResultE = ALU result when MDEnE=0.
- Branch condition is evaluated on the forwarded rs1/rs2, never on the ALU:
  - 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge.
  - 010/011 → 0.
  - cond_trueE = BranchE & cond.
- M-unit FSM states, all of which reset to IDLE:
  - IDLE:
    - If MDEnE & !FlushE, latch the forwarded operands, sign flags and MDOpE, and go to BUSY.
    - md_stallE = 1 combinationally in this issue cycle.
  - BUSY:
    - Runs a count-up counter 0..XLEN-1 with one bit per cycle: shift-add multiply (2·XLEN product) or restoring divide on absolute values.
    - md_stallE = 1.
    - When the counter reaches XLEN-1, go to DONE.
  - DONE:
    - Sign-corrected result is registered; ALUResultE = md result and md_stallE = 0.
    - Go to IDLE unless StallE = 1, in which case hold in DONE with the result stable.
- Latency: the issue cycle plus XLEN BUSY cycles plus one DONE cycle, i.e. XLEN+2 cycles in EX. EX/MEM captures on the last edge of DONE.
- Operands are latched at issue, so forwarding-source changes during the stall have no effect.
- Result selection:
  - MUL: low XLEN bits. MULH/MULHSU/MULHU: high XLEN bits (MULHSU treats rs1 signed, rs2 unsigned).
  - Signed ops negate the magnitude result when the operand signs differ; the remainder takes the dividend's sign.
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed overflow (-2^(XLEN-1) / -1): quotient = dividend; remainder = 0.
- FlushE in BUSY or DONE: go to IDLE next cycle, md_stallE = 0 from the next cycle, no result.
- rst_n low at any time: FSM IDLE, counter 0, operand/result registers 0, md_stallE = 0.
- Outputs during reset:
  - ALUResultE reflects the combinational ALU path.
  - WriteDataE and PCTargetE follow their inputs.
- A new MDEnE instruction arriving in the cycle after DONE issues normally (back-to-back M ops).

Optional Feature:
- Macro MD_EARLY_OUT_EN.
- Defined: these cases skip BUSY, going IDLE → DONE with latency 2:
  - divide by zero;
  - signed overflow;
  - either multiply operand zero (result 0).
- Not defined: every M op takes the fixed XLEN+2 cycles.

Test Plan:
- ADD with ForwardAE=10, ALUResultM=5, rs1=9, rs2=3 → ALUResultE=8, md_stallE=0.
- BLT with rs1=0xFFFFFFFF, rs2=1 → cond_trueE=1; BLTU with the same operands → cond_trueE=0.
- MULH rs1=0x80000000, rs2=2 → md_stallE high for 33 cycles, then ALUResultE=0xFFFFFFFF in DONE; MUL gives 0x00000000.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000; REM 7/0 → 7; DIVU 7/0 → 0xFFFFFFFF (34 cycles, or 2 with MD_EARLY_OUT_EN).
- Change ResultW while BUSY on DIVU 100/7 → result stays 14; StallE=1 in DONE for 3 cycles → result held and FSM stays in DONE.
- FlushE at BUSY counter 10, and separately rst_n low mid-BUSY → IDLE next cycle, md_stallE=0, the next MUL 6×7 returns 42.
